// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the 256x8 data memory between port A and port B.
// Define DMEM_ARB_CLEAR_EN to compile in the clear-sweep engine (SWEEP state, Cnt, Busy/Done).
module dmem_arbiter #(
    parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       AReq,
    input  logic       AWrite,
    input  logic [7:0] AAddr,
    input  logic [7:0] AWData,
    output logic       AGnt,
    output logic [7:0] ARData,
    output logic       ARValid,
    input  logic       BReq,
    input  logic       BWrite,
    input  logic [7:0] BAddr,
    input  logic [7:0] BWData,
    output logic       BGnt,
    output logic [7:0] BRData,
    output logic       BRValid,
    input  logic       Clear,
    output logic       Busy,
    output logic       Done,
    output logic       MemWriteEn,
    output logic [7:0] MemAddr,
    output logic [7:0] MemDataIn,
    input  logic [7:0] MemDataOut
);

    logic       last_q;      // 1 = port B won the most recent grant
    logic       last_d;
    logic       a_rvalid_q;
    logic       b_rvalid_q;
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;
    logic       sweep;
    logic [7:0] sweep_addr;

`ifdef DMEM_ARB_CLEAR_EN
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       done_q;

    assign sweep      = (state_q == SWEEP);
    assign sweep_addr = cnt_q;
    assign Busy       = sweep;
    assign Done       = done_q;
`else
    logic unused_clear;

    assign unused_clear = Clear;
    assign sweep        = 1'b0;
    assign sweep_addr   = 8'h00;
    assign Busy         = 1'b0;
    assign Done         = 1'b0;
`endif

    // A tie goes to whichever port did not win last; a lone requester always wins.
    assign AGnt   = !Reset && !sweep && AReq && (!BReq || last_q);
    assign BGnt   = !Reset && !sweep && BReq && (!AReq || !last_q);
    assign last_d = (AGnt || BGnt) ? BGnt : last_q;

    assign ARData  = a_rdata_q;
    assign BRData  = b_rdata_q;
    assign ARValid = a_rvalid_q;
    assign BRValid = b_rvalid_q;

    always_comb begin
        // NOTE: every output gets a default before the branches, so no path can infer a latch.
        MemWriteEn = 1'b0;
        MemAddr    = 8'h00;
        MemDataIn  = 8'h00;
        if (!Reset && sweep) begin
            MemWriteEn = 1'b1;
            MemAddr    = sweep_addr;
            MemDataIn  = CLEAR_VALUE;
        end else if (AGnt) begin
            MemWriteEn = AWrite;
            MemAddr    = AAddr;
            MemDataIn  = AWData;
        end else if (BGnt) begin
            MemWriteEn = BWrite;
            MemAddr    = BAddr;
            MemDataIn  = BWData;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q     <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 8'h00;
            b_rdata_q  <= 8'h00;
`ifdef DMEM_ARB_CLEAR_EN
            state_q    <= IDLE;
            cnt_q      <= 8'h00;
            done_q     <= 1'b0;
`endif
        end else begin
            last_q     <= last_d;
            a_rvalid_q <= AGnt && !AWrite;
            b_rvalid_q <= BGnt && !BWrite;
            if (AGnt && !AWrite) a_rdata_q <= MemDataOut;
            if (BGnt && !BWrite) b_rdata_q <= MemDataOut;
`ifdef DMEM_ARB_CLEAR_EN
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Clear) begin
                        state_q <= SWEEP;
                        cnt_q   <= 8'h00;
                    end
                end
                SWEEP: begin
                    cnt_q <= cnt_q + 8'h01;
                    // The write to address 255 lands on this edge; Done shows in the first IDLE cycle.
                    if (cnt_q == 8'hFF) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x8 memory attached.
// Clear-engine scenarios run when DMEM_ARB_CLEAR_EN is defined; otherwise Clear must be inert.
module tb_dmem_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       AReq = 1'b0, AWrite = 1'b0, BReq = 1'b0, BWrite = 1'b0, Clear = 1'b0;
  logic [7:0] AAddr = 8'h00, AWData = 8'h00, BAddr = 8'h00, BWData = 8'h00;
  logic       AGnt, BGnt, ARValid, BRValid, Busy, Done, MemWriteEn;
  logic [7:0] ARData, BRData, MemAddr, MemDataIn, MemDataOut;
  logic [7:0] mem [256];
  int         total = 0;
  int         bad = 0;

  dmem_arbiter #(.CLEAR_VALUE(8'h00)) dut (
    .Clk(Clk), .Reset(Reset),
    .AReq(AReq), .AWrite(AWrite), .AAddr(AAddr), .AWData(AWData),
    .AGnt(AGnt), .ARData(ARData), .ARValid(ARValid),
    .BReq(BReq), .BWrite(BWrite), .BAddr(BAddr), .BWData(BWData),
    .BGnt(BGnt), .BRData(BRData), .BRValid(BRValid),
    .Clear(Clear), .Busy(Busy), .Done(Done),
    .MemWriteEn(MemWriteEn), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  always #5 Clk = ~Clk;

  assign MemDataOut = mem[MemAddr];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddr] <= MemDataIn;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [7:0] data);
    AReq = 1'b1; AWrite = 1'b1; AAddr = addr; AWData = data;
    #1;
    total++;
    if ({AGnt, MemWriteEn, MemAddr, MemDataIn} !== {1'b1, 1'b1, addr, data}) begin
      bad++;
      $display("FAIL write_a addr=%h got gnt=%b we=%b a=%h d=%h", addr, AGnt, MemWriteEn, MemAddr, MemDataIn);
    end
    tick();
    AReq = 1'b0; AWrite = 1'b0;
  endtask

  task automatic read_a(input logic [7:0] addr, input logic [7:0] exp, input string name);
    AReq = 1'b1; AWrite = 1'b0; AAddr = addr;
    #1;
    tick();
    AReq = 1'b0;
    total++;
    if ({ARValid, ARData} !== {1'b1, exp}) begin
      bad++;
      $display("FAIL %s addr=%h got valid=%b data=%h want valid=1 data=%h", name, addr, ARValid, ARData, exp);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; AReq = 1'b1; BReq = 1'b1; AWrite = 1'b1; AAddr = 8'h33; AWData = 8'h99;
    #1;
    total++;
    if ({AGnt, BGnt, MemWriteEn, MemAddr, MemDataIn} !== 19'h0) begin
      bad++;
      $display("FAIL reset_comb got gnt=%b%b we=%b a=%h d=%h want all 0", AGnt, BGnt, MemWriteEn, MemAddr, MemDataIn);
    end
    tick();
    total++;
    if ({ARValid, BRValid, Busy, Done, ARData, BRData} !== 20'h0) begin
      bad++;
      $display("FAIL reset_regs got rv=%b%b busy=%b done=%b ard=%h brd=%h want all 0", ARValid, BRValid, Busy, Done, ARData, BRData);
    end
    AReq = 1'b0; BReq = 1'b0; AWrite = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_reset();
    write_a(8'h10, 8'h5A);
    total++;
    if (ARValid !== 1'b0) begin
      bad++;
      $display("FAIL write_no_rvalid got=%b want=0", ARValid);
    end
    AReq = 1'b1; AWrite = 1'b0; AAddr = 8'h10;
    #1;
    total++;
    if ({AGnt, BGnt, MemWriteEn, MemAddr} !== {3'b100, 8'h10}) begin
      bad++;
      $display("FAIL read_grant got gnt=%b%b we=%b a=%h want 1 0 0 10", AGnt, BGnt, MemWriteEn, MemAddr);
    end
    tick();
    AReq = 1'b0;
    total++;
    if ({ARValid, ARData, BRValid} !== {1'b1, 8'h5A, 1'b0}) begin
      bad++;
      $display("FAIL read_data got av=%b ad=%h bv=%b want 1 5a 0", ARValid, ARData, BRValid);
    end
    tick();
    total++;
    if ({ARValid, ARData} !== {1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL read_hold got av=%b ad=%h want 0 5a", ARValid, ARData);
    end
  endtask

  task automatic test_round_robin();
    write_a(8'h01, 8'h77);
    do_reset();
    AReq = 1'b1; BReq = 1'b1; AWrite = 1'b0; BWrite = 1'b0; AAddr = 8'h01; BAddr = 8'h01;
    for (int i = 0; i < 4; i++) begin
      logic exp_a;
      exp_a = (i % 2 == 0);
      #1;
      total++;
      if ({AGnt, BGnt} !== {exp_a, !exp_a}) begin
        bad++;
        $display("FAIL rr_grant cycle=%0d got=%b%b want=%b%b", i, AGnt, BGnt, exp_a, !exp_a);
      end
      tick();
      total++;
      if ({ARValid, BRValid} !== {exp_a, !exp_a} || (exp_a ? ARData : BRData) !== 8'h77) begin
        bad++;
        $display("FAIL rr_rvalid cycle=%0d got rv=%b%b ad=%h bd=%h want rv=%b%b data=77", i, ARValid, BRValid, ARData, BRData, exp_a, !exp_a);
      end
    end
    AReq = 1'b0; BReq = 1'b0;
    tick();
  endtask

  task automatic test_first_tie();
    do_reset();
    BReq = 1'b1; BWrite = 1'b0; BAddr = 8'h01;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({AGnt, BGnt} !== 2'b01) begin
        bad++;
        $display("FAIL b_alone cycle=%0d got=%b%b want=01", i, AGnt, BGnt);
      end
      tick();
    end
    AReq = 1'b1; AWrite = 1'b0; AAddr = 8'h10;
    #1;
    total++;
    if ({AGnt, BGnt} !== 2'b10) begin
      bad++;
      $display("FAIL tie_a_wins got=%b%b want=10", AGnt, BGnt);
    end
    tick();
    total++;
    if ({AGnt, BGnt, ARData} !== {2'b01, 8'h5A}) begin
      bad++;
      $display("FAIL tie_then_b got=%b%b ad=%h want=01 5a", AGnt, BGnt, ARData);
    end
    AReq = 1'b0; BReq = 1'b0;
    tick();
  endtask

`ifdef DMEM_ARB_CLEAR_EN
  task automatic test_clear();
    int errs;
    int first_k;
    errs = 0;
    first_k = -1;
    write_a(8'h00, 8'hFF);
    write_a(8'h80, 8'hFF);
    write_a(8'hFF, 8'hFF);
    AReq = 1'b1; AWrite = 1'b0; AAddr = 8'h05; Clear = 1'b1;
    #1;
    total++;
    if (AGnt !== 1'b1) begin
      bad++;
      $display("FAIL clear_cycle_grant got=%b want=1", AGnt);
    end
    tick();
    Clear = 1'b0;
    for (int k = 0; k < 256; k++) begin
      #1;
      if (!(Busy === 1'b1 && AGnt === 1'b0 && MemWriteEn === 1'b1 && MemAddr === 8'(k) && MemDataIn === 8'h00)) begin
        if (first_k < 0) first_k = k;
        errs++;
      end
      tick();
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL sweep_cycles bad_cycles=%0d first=%0d want 0", errs, first_k);
    end
    #1;
    total++;
    if ({Busy, Done, AGnt} !== 3'b011) begin
      bad++;
      $display("FAIL sweep_end got busy=%b done=%b gnt=%b want 0 1 1", Busy, Done, AGnt);
    end
    tick();
    AReq = 1'b0;
    total++;
    if (Done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b want=0", Done);
    end
    read_a(8'h00, 8'h00, "clear_addr0");
    read_a(8'h80, 8'h00, "clear_addr128");
    read_a(8'hFF, 8'h00, "clear_addr255");
  endtask

  task automatic test_reset_mid_sweep();
    write_a(8'd150, 8'h44);
    write_a(8'd50, 8'hAA);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (100) tick();
    total++;
    if ({Busy, MemAddr} !== {1'b1, 8'd100}) begin
      bad++;
      $display("FAIL sweep_at_100 got busy=%b a=%0d want 1 100", Busy, MemAddr);
    end
    Reset = 1'b1;
    #1;
    total++;
    if (MemWriteEn !== 1'b0) begin
      bad++;
      $display("FAIL reset_blocks_write got=%b want=0", MemWriteEn);
    end
    tick();
    Reset = 1'b0;
    total++;
    if ({Busy, Done} !== 2'b00) begin
      bad++;
      $display("FAIL abort got busy=%b done=%b want 0 0", Busy, Done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (Done !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done cycle=%0d got=%b want=0", i, Done);
      end
    end
    read_a(8'd150, 8'h44, "abort_addr150");
    read_a(8'd50, 8'h00, "abort_addr50");
    Reset = 1'b1; Clear = 1'b1;
    tick();
    Reset = 1'b0; Clear = 1'b0;
    tick();
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_in_reset got busy=%b want=0", Busy);
    end
  endtask
`else
  task automatic test_clear_disabled();
    write_a(8'h20, 8'hFF);
    AReq = 1'b1; AWrite = 1'b0; AAddr = 8'h20; Clear = 1'b1;
    #1;
    tick();
    Clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({Busy, Done, AGnt, ARValid, ARData, MemWriteEn} !== {4'b0011, 8'hFF, 1'b0}) begin
        bad++;
        $display("FAIL no_clear cycle=%0d got busy=%b done=%b gnt=%b av=%b ad=%h we=%b", i, Busy, Done, AGnt, ARValid, ARData, MemWriteEn);
      end
      tick();
    end
    AReq = 1'b0;
    tick();
    read_a(8'h20, 8'hFF, "no_clear_mem");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_round_robin();
    test_first_tie();
`ifdef DMEM_ARB_CLEAR_EN
    test_clear();
    test_reset_mid_sweep();
`else
    test_clear_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
